// File: rtl/reg_file_sb_pkg.sv
// Shared defines for the register-file slice: machine word and register-file
// size constants, plus the defaults the reg_file_sb blocks are built from.
package reg_file_sb_pkg;

  localparam int XLEN          = 32;
  localparam int REGFILE_DEPTH = 32;

  localparam int WORD_LEN_DEF  = XLEN;
  localparam int ADDR_LEN_DEF  = $clog2(REGFILE_DEPTH);
  localparam int RD_PORTS_DEF  = 2;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, writeback, reservation and
// scoreboard status. The register file is the slave side.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF
) ();

  logic [RD_PORTS*ADDR_LEN-1:0] rd_addr;
  logic [RD_PORTS*WORD_LEN-1:0] rd_data;
  logic [RD_PORTS-1:0]          rd_busy;

  logic                         wr_en;
  logic [ADDR_LEN-1:0]          wr_addr;
  logic [WORD_LEN-1:0]          wr_data;

  logic                         rsv_en;
  logic [ADDR_LEN-1:0]          rsv_addr;
  logic                         rsv_ok;

  logic                         flush;
  logic [ADDR_LEN:0]            busy_cnt;
  logic                         any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rsv_ok, busy_cnt, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rsv_ok, busy_cnt, any_busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of busy entries. Register 0 is never marked busy.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  localparam int DEPTH   = 2**ADDR_LEN,
  localparam int CNT_W   = ADDR_LEN + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_LEN-1:0] rsv_addr,
  input  logic                flush,
  output logic [DEPTH-1:0]    busy,
  output logic                rsv_ok,
  output logic [CNT_W-1:0]    busy_cnt,
  output logic                any_busy
);

  logic             wr_nz;
  logic             rsv_nz;
  logic             wr_same;
  logic             rsv_sets;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] cnt_next;

  assign wr_nz   = wr_en && (wr_addr != '0);
  assign rsv_nz  = (rsv_addr != '0);
  assign wr_same = wr_nz && (wr_addr == rsv_addr);

  // A reservation cannot be accepted while reset holds the scoreboard clear.
  assign rsv_ok   = rst && rsv_en && !flush && (!rsv_nz || !busy[rsv_addr] || wr_same);
  assign rsv_sets = rsv_ok && rsv_nz;

  // A write racing a reservation to the same busy entry leaves it busy, so
  // that write must not decrement the count.
  assign cnt_inc = rsv_sets && !busy[rsv_addr];
  assign cnt_dec = wr_nz && busy[wr_addr] && !(rsv_sets && wr_same);

  always_comb begin
    // NOTE: combinational logic uses blocking '=' with a default first, so
    // every path assigns and no latch is inferred.
    busy_next = busy;
    if (wr_nz)    busy_next[wr_addr]  = 1'b0;
    if (rsv_sets) busy_next[rsv_addr] = 1'b1;
    cnt_next = busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      any_busy <= 1'b0;
    end else if (flush) begin
      busy     <= '0;
      busy_cnt <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      any_busy <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with writeback bypass and a reservation
// scoreboard. Register 0 is hardwired to zero and never busy.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_LEN;

  logic [WORD_LEN-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]             busy;
  logic                         wr_nz;
  logic [RD_PORTS*WORD_LEN-1:0] rd_data;
  logic [RD_PORTS-1:0]          rd_busy;

  assign wr_nz = bus.wr_en && (bus.wr_addr != '0);

  // NOTE: the storage array is reset on purpose: reset must clear every
  // entry immediately, so this stays flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_nz) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Bypass stays live during reset; storage reads zero then anyway.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      logic [ADDR_LEN-1:0] a;
      logic                hit;
      a   = bus.rd_addr[k*ADDR_LEN +: ADDR_LEN];
      hit = wr_nz && (bus.wr_addr == a);
      if (hit)
        rd_data[k*WORD_LEN +: WORD_LEN] = bus.wr_data;
      else if (a != '0)
        rd_data[k*WORD_LEN +: WORD_LEN] = mem[a];
      rd_busy[k] = busy[a] && !hit;
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;

  reg_scoreboard #(
    .ADDR_LEN (ADDR_LEN)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .busy     (busy),
    .rsv_ok   (bus.rsv_ok),
    .busy_cnt (bus.busy_cnt),
    .any_busy (bus.any_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus pushes expected values into a
// queue, a monitor process pops and compares them against the DUT.
module tb_reg_file_sb;

  typedef enum int {F_DATA0, F_DATA1, F_BUSY0, F_BUSY1, F_RSVOK, F_CNT, F_ANY} field_e;

  typedef struct {
    field_e      f;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] actual(field_e f);
    case (f)
      F_DATA0: return bus.rd_data[31:0];
      F_DATA1: return bus.rd_data[63:32];
      F_BUSY0: return {31'd0, bus.rd_busy[0]};
      F_BUSY1: return {31'd0, bus.rd_busy[1]};
      F_RSVOK: return {31'd0, bus.rsv_ok};
      F_CNT:   return {26'd0, bus.busy_cnt};
      default: return {31'd0, bus.any_busy};
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [31:0] act;
    act = actual(e.f);
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
    end
  endtask

  // Monitor: drains every queued expectation each time stimulus signals.
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) check(q.pop_front());
    end
  end

  task automatic expect_val(input field_e f, input logic [31:0] v, input string n);
    q.push_back('{f: f, exp: v, name: n});
  endtask

  task automatic settle();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic reserve(input logic [4:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    set_rd(5'd5, 5'd0);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd3;

    // Reset state
    #3;
    expect_val(F_CNT,   0, "reset_cnt");
    expect_val(F_ANY,   0, "reset_any");
    expect_val(F_DATA0, 0, "reset_data0");
    expect_val(F_RSVOK, 0, "reset_rsv_ok");
    settle();
    idle();
    #4 rst = 1'b1;
    tick();

    // Write r5, read it next cycle; r0 reads zero
    write(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_rd(5'd5, 5'd0);
    expect_val(F_DATA0, 32'hDEADBEEF, "r5_read");
    expect_val(F_DATA1, 0,            "r0_read");
    settle();

    // Same-cycle bypass before the edge
    write(5'd7, 32'h1234);
    set_rd(5'd7, 5'd5);
    expect_val(F_DATA0, 32'h1234,     "bypass_data");
    expect_val(F_BUSY0, 0,            "bypass_busy");
    expect_val(F_DATA1, 32'hDEADBEEF, "bypass_other_port");
    settle();
    tick();
    idle();

    // Reserve r3, re-reserve rejected, write clears
    reserve(5'd3);
    expect_val(F_RSVOK, 1, "rsv3_ok");
    settle();
    tick();
    idle();
    set_rd(5'd3, 5'd3);
    expect_val(F_CNT,   1, "rsv3_cnt");
    expect_val(F_ANY,   1, "rsv3_any");
    expect_val(F_BUSY0, 1, "rsv3_busy0");
    expect_val(F_BUSY1, 1, "rsv3_busy1");
    reserve(5'd3);
    expect_val(F_RSVOK, 0, "rsv3_again_rejected");
    settle();
    tick();
    idle();
    expect_val(F_CNT, 1, "rsv3_again_cnt");
    write(5'd3, 32'hA5);
    expect_val(F_BUSY0, 0,     "wr3_bypass_busy");
    expect_val(F_DATA1, 32'hA5, "wr3_bypass_data");
    settle();
    tick();
    idle();
    expect_val(F_CNT,   0,      "wr3_cnt");
    expect_val(F_ANY,   0,      "wr3_any");
    expect_val(F_BUSY0, 0,      "wr3_busy");
    expect_val(F_DATA0, 32'hA5, "wr3_data");
    settle();

    // Reserve r0: accepted, no effect
    reserve(5'd0);
    set_rd(5'd0, 5'd0);
    expect_val(F_RSVOK, 1, "rsv0_ok");
    settle();
    tick();
    idle();
    expect_val(F_CNT,   0, "rsv0_cnt");
    expect_val(F_BUSY0, 0, "rsv0_busy");
    settle();

    // Reserve and write r4 in the same cycle while busy
    reserve(5'd4);
    tick();
    idle();
    expect_val(F_CNT, 1, "rsv4_cnt");
    settle();
    reserve(5'd4);
    write(5'd4, 32'h44);
    expect_val(F_RSVOK, 1, "rsv4_wr4_ok");
    settle();
    tick();
    idle();
    set_rd(5'd4, 5'd0);
    expect_val(F_BUSY0, 1,      "rsv4_wr4_busy");
    expect_val(F_CNT,   1,      "rsv4_wr4_cnt");
    expect_val(F_DATA0, 32'h44, "rsv4_wr4_data");
    settle();
    write(5'd4, 32'h45);
    tick();
    idle();
    expect_val(F_CNT, 0, "wr4_clear_cnt");
    settle();

    // Reserve r1, r2, r9 then flush with a write to r2
    reserve(5'd1);
    tick();
    reserve(5'd2);
    tick();
    reserve(5'd9);
    tick();
    idle();
    expect_val(F_CNT, 3, "three_rsv_cnt");
    expect_val(F_ANY, 1, "three_rsv_any");
    settle();
    bus.flush = 1'b1;
    write(5'd2, 32'h55);
    reserve(5'd10);
    expect_val(F_RSVOK, 0, "flush_rsv_ok");
    settle();
    tick();
    idle();
    set_rd(5'd2, 5'd9);
    expect_val(F_CNT,   0,      "flush_cnt");
    expect_val(F_ANY,   0,      "flush_any");
    expect_val(F_DATA0, 32'h55, "flush_r2_data");
    expect_val(F_BUSY0, 0,      "flush_r2_busy");
    expect_val(F_BUSY1, 0,      "flush_r9_busy");
    settle();

    // Reserve r6, write r8, then asynchronous reset between edges
    reserve(5'd6);
    tick();
    idle();
    write(5'd8, 32'hFF);
    tick();
    idle();
    set_rd(5'd8, 5'd6);
    expect_val(F_DATA0, 32'hFF, "pre_rst_r8");
    expect_val(F_CNT,   1,      "pre_rst_cnt");
    settle();
    rst = 1'b0;
    expect_val(F_DATA0, 0, "rst_r8_data");
    expect_val(F_BUSY1, 0, "rst_r6_busy");
    expect_val(F_CNT,   0, "rst_cnt");
    expect_val(F_ANY,   0, "rst_any");
    settle();
    write(5'd8, 32'h77);
    expect_val(F_DATA0, 32'h77, "rst_bypass_data");
    settle();
    tick();
    idle();
    expect_val(F_DATA0, 0, "rst_write_ignored");
    settle();
    rst = 1'b1;
    settle();
    tick();
    write(5'd8, 32'h99);
    tick();
    idle();
    expect_val(F_DATA0, 32'h99, "post_rst_write");
    expect_val(F_CNT,   0,      "post_rst_cnt");
    settle();

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
